// File: rtl/uwasic_pkg.sv
// Shared constants and helpers for the onboarding SPI/PWM block.
package uwasic_pkg;

    localparam int FRAME_BITS = 16;
    localparam int ADDR_W     = 7;

    localparam logic [ADDR_W-1:0] ADDR_EN_LO  = 7'h00;
    localparam logic [ADDR_W-1:0] ADDR_EN_HI  = 7'h01;
    localparam logic [ADDR_W-1:0] ADDR_PWM_LO = 7'h02;
    localparam logic [ADDR_W-1:0] ADDR_PWM_HI = 7'h03;
    localparam logic [ADDR_W-1:0] ADDR_DUTY   = 7'h04;
    localparam logic [ADDR_W-1:0] ADDR_MAX    = 7'h04;

    // A decoded SPI frame: R/W flag, register address, payload.
    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } frame_t;

    // Addresses above the last register are silently dropped.
    function automatic logic addr_valid(input logic [ADDR_W-1:0] a);
        return a <= ADDR_MAX;
    endfunction

endpackage

// File: rtl/uwasic_onboarding_joe_ji_spi_peripheral.sv
// Write-only SPI (mode 0, MSB first) register file: input synchronizers,
// 16-bit framing and the five configuration registers.
module spi_peripheral
    import uwasic_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk_i,
    input  logic       copi_i,
    input  logic       ncs_i,
    output logic [7:0] en_out_lo_o,
    output logic [7:0] en_out_hi_o,
    output logic [7:0] en_pwm_lo_o,
    output logic [7:0] en_pwm_hi_o,
    output logic [7:0] duty_o
);

    localparam int CNT_W = $clog2(FRAME_BITS + 1);

    logic [SYNC_STAGES-1:0] sclk_sync_q, copi_sync_q, ncs_sync_q;
    logic                   sclk_prev_q, ncs_prev_q;
    logic                   sclk_s, copi_s, ncs_s;
    logic                   sclk_rise, ncs_fall, ncs_rise;

    logic [FRAME_BITS-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [7:0]             en_lo_q, en_lo_d, en_hi_q, en_hi_d;
    logic [7:0]             pw_lo_q, pw_lo_d, pw_hi_q, pw_hi_d;
    logic [7:0]             duty_q, duty_d;
    frame_t                 frame;

    // Metastability chains plus one history flop for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            copi_sync_q <= '0;
            ncs_sync_q  <= '0;
            sclk_prev_q <= 1'b0;
            ncs_prev_q  <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
            copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi_i};
            ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs_i};
            sclk_prev_q <= sclk_s;
            ncs_prev_q  <= ncs_s;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign copi_s    = copi_sync_q[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign ncs_fall  = ~ncs_s & ncs_prev_q;
    assign ncs_rise  = ncs_s & ~ncs_prev_q;
    assign frame     = frame_t'(shift_q);

    // Framing and commit: shift while selected, write on deselect if the frame is a full valid write.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        en_lo_d = en_lo_q;
        en_hi_d = en_hi_q;
        pw_lo_d = pw_lo_q;
        pw_hi_d = pw_hi_q;
        duty_d  = duty_q;
        if (ncs_fall) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (!ncs_s && sclk_rise && cnt_q < CNT_W'(FRAME_BITS)) begin
            shift_d = {shift_q[FRAME_BITS-2:0], copi_s};
            cnt_d   = cnt_q + CNT_W'(1);
        end
        if (ncs_rise && cnt_q == CNT_W'(FRAME_BITS) && frame.wr && addr_valid(frame.addr)) begin
            case (frame.addr)
                ADDR_EN_LO:  en_lo_d = frame.data;
                ADDR_EN_HI:  en_hi_d = frame.data;
                ADDR_PWM_LO: pw_lo_d = frame.data;
                ADDR_PWM_HI: pw_hi_d = frame.data;
                ADDR_DUTY:   duty_d  = frame.data;
                default:     ;
            endcase
        end
    end

    // Frame state and register file.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
            en_lo_q <= '0;
            en_hi_q <= '0;
            pw_lo_q <= '0;
            pw_hi_q <= '0;
            duty_q  <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            en_lo_q <= en_lo_d;
            en_hi_q <= en_hi_d;
            pw_lo_q <= pw_lo_d;
            pw_hi_q <= pw_hi_d;
            duty_q  <= duty_d;
        end
    end

    assign en_out_lo_o = en_lo_q;
    assign en_out_hi_o = en_hi_q;
    assign en_pwm_lo_o = pw_lo_q;
    assign en_pwm_hi_o = pw_hi_q;
    assign duty_o      = duty_q;

endmodule

// File: rtl/uwasic_onboarding_joe_ji.sv
// TinyTapeout top: SPI-configured static/PWM drive of 16 outputs.
module uwasic_onboarding_joe_ji
    import uwasic_pkg::*;
#(
    parameter int CLK_DIV     = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int PS_W = $clog2(CLK_DIV + 1);

    logic [7:0]      en_lo, en_hi, pw_lo, pw_hi, duty;
    logic [15:0]     en_out, en_pwm;
    logic [PS_W-1:0] presc_q;
    logic [7:0]      pwm_cnt_q;
    logic            pwm;
    logic [15:0]     out_q, out_d;
    logic            unused_ok;

    spi_peripheral #(.SYNC_STAGES(SYNC_STAGES)) u_spi (
        .clk         (clk),
        .rst_n       (rst_n),
        .sclk_i      (ui_in[0]),
        .copi_i      (ui_in[1]),
        .ncs_i       (ui_in[2]),
        .en_out_lo_o (en_lo),
        .en_out_hi_o (en_hi),
        .en_pwm_lo_o (pw_lo),
        .en_pwm_hi_o (pw_hi),
        .duty_o      (duty)
    );

    assign en_out = {en_hi, en_lo};
    assign en_pwm = {pw_hi, pw_lo};

    // Prescaler divides clk by CLK_DIV+1; each wrap steps the 8-bit PWM phase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q   <= '0;
            pwm_cnt_q <= '0;
        end else if (presc_q == PS_W'(CLK_DIV)) begin
            presc_q   <= '0;
            pwm_cnt_q <= pwm_cnt_q + 8'd1;
        end else begin
            presc_q   <= presc_q + PS_W'(1);
        end
    end

    // 0xFF is forced fully on, otherwise the top count would leave one low step.
    assign pwm = (duty == 8'hFF) | (pwm_cnt_q < duty);

    // Per-bit output select: off, static high, or shared PWM.
    always_comb begin
        out_d = en_out & (~en_pwm | {16{pwm}});
    end

    // Register outputs to keep pins glitch-free.
    always_ff @(posedge clk) begin
        if (!rst_n) out_q <= '0;
        else        out_q <= out_d;
    end

    assign uo_out    = out_q[7:0];
    assign uio_out   = out_q[15:8];
    assign uio_oe    = 8'hFF;
    assign unused_ok = &{1'b0, ena, uio_in, ui_in[7:3]};

endmodule

// File: tb/tb_uwasic_onboarding_joe_ji.sv
// Directed self-checking bench for the SPI/PWM onboarding block.
module tb_uwasic_onboarding_joe_ji;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks = 0;
    int errors = 0;

    uwasic_onboarding_joe_ji dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;   // 10 MHz

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Send the top nbits of w, MSB first; SCLK half-period is 5 clk cycles.
    task automatic spi_frame(input logic [15:0] w, input int nbits);
        ui_in[2] = 1'b0;
        clks(5);
        for (int i = 15; i > 15 - nbits; i--) begin
            ui_in[1] = w[i];
            clks(5);
            ui_in[0] = 1'b1;
            clks(5);
            ui_in[0] = 1'b0;
        end
        clks(5);
        ui_in[2] = 1'b1;
        clks(8);
    endtask

    task automatic spi_write(input logic [6:0] addr, input logic [7:0] data);
        spi_frame({1'b1, addr, data}, 16);
    endtask

    // Wait until uo_out[0] equals lvl; cyc counts the cycles spent waiting.
    task automatic wait_level(input logic lvl, output int cyc, output bit ok);
        cyc = 0;
        while (uo_out[0] !== lvl && cyc < 10000) begin
            @(negedge clk);
            cyc++;
        end
        ok = (uo_out[0] === lvl);
    endtask

    // Count cycles uo_out[0] is high over a window.
    task automatic count_high(input int n, output int hi);
        hi = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (uo_out[0] === 1'b1) hi++;
        end
    endtask

    initial begin
        int  cyc, hi_t, lo_t, hi_cnt;
        bit  ok;

        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h04;   // nCS idle high
        uio_in = 8'h00;
        clks(5);
        rst_n = 1'b1;
        clks(3);

        chk("reset_uo",  uo_out,  8'h00);
        chk("reset_uio", uio_out, 8'h00);
        chk("reset_oe",  uio_oe,  8'hFF);

        // Static enables.
        spi_write(7'h00, 8'hF0);
        spi_write(7'h01, 8'hCC);
        chk("static_uo",  uo_out,  8'hF0);
        chk("static_uio", uio_out, 8'hCC);

        // Discarded frames: read, far address, first invalid address.
        spi_frame(16'h00FF, 16);
        chk("read_ignored", uo_out, 8'hF0);
        spi_frame(16'hB0AA, 16);
        chk("addr30_uo",  uo_out,  8'hF0);
        chk("addr30_uio", uio_out, 8'hCC);
        spi_frame(16'h8577, 16);
        chk("addr05_uo",  uo_out,  8'hF0);
        chk("addr05_uio", uio_out, 8'hCC);

        // Short frame (10 bits) then a full write.
        spi_frame(16'h80FF, 10);
        chk("short_ignored", uo_out, 8'hF0);
        spi_write(7'h00, 8'h01);
        chk("after_short_uo",  uo_out,  8'h01);
        chk("after_short_uio", uio_out, 8'hCC);

        // PWM at 50%: period 13*256 = 3328 clk (~3005 Hz), high 1664.
        spi_write(7'h02, 8'h01);
        spi_write(7'h04, 8'h80);
        wait_level(1'b0, cyc, ok); chk("pwm_to0", ok, 1'b1);
        wait_level(1'b1, cyc, ok); chk("pwm_to1", ok, 1'b1);
        wait_level(1'b0, hi_t, ok); chk("pwm_fall", ok, 1'b1);
        wait_level(1'b1, lo_t, ok); chk("pwm_rise", ok, 1'b1);
        chk("pwm50_high",   hi_t, 1664);
        chk("pwm50_period", hi_t + lo_t, 3328);
        chk("pwm50_uio", uio_out, 8'hCC);

        // duty=1: one prescaler step high per period.
        spi_write(7'h04, 8'h01);
        wait_level(1'b1, cyc, ok); chk("d1_to1", ok, 1'b1);
        wait_level(1'b0, hi_t, ok); chk("d1_fall", ok, 1'b1);
        chk("duty1_high", hi_t, 13);

        // duty=0 constant low, duty=0xFF constant high.
        spi_write(7'h04, 8'h00);
        count_high(4000, hi_cnt);
        chk("duty00_high", hi_cnt, 0);
        spi_write(7'h04, 8'hFF);
        count_high(4000, hi_cnt);
        chk("dutyFF_high", hi_cnt, 4000);

        // Reset in the middle of a frame.
        ui_in[2] = 1'b0;
        clks(5);
        for (int i = 0; i < 8; i++) begin
            ui_in[1] = 1'b1;
            clks(5);
            ui_in[0] = 1'b1;
            clks(5);
            ui_in[0] = 1'b0;
        end
        rst_n = 1'b0;
        clks(3);
        chk("midrst_uo",  uo_out,  8'h00);
        chk("midrst_uio", uio_out, 8'h00);
        chk("midrst_oe",  uio_oe,  8'hFF);
        ui_in[2] = 1'b1;
        clks(3);
        rst_n = 1'b1;
        clks(5);
        chk("postrst_uo", uo_out, 8'h00);
        spi_write(7'h01, 8'h5A);
        chk("postrst_uio",   uio_out, 8'h5A);
        chk("postrst_uo2",   uo_out,  8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
